// File: rtl/nios_pio_pkg.sv
// Shared constants for the PIO input capture block: register map, edge modes, status bits.
package nios_pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_SNAPSHOT = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_CTRL     = 3'd4;
  localparam logic [2:0] ADDR_STATUS   = 3'd5;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

  localparam int unsigned STAT_VALID_BIT = 0;
  localparam int unsigned STAT_OVF_BIT   = 1;

endpackage

// File: rtl/nios_pio_in_cap_if.sv
// Avalon-MM slave bus bundle for the PIO input capture block.
interface nios_pio_in_cap_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        read;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, read, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/pio_sync_edge.sv
// Two-flop synchroniser with a previous-value flop and per-bit edge detection.
module pio_sync_edge
  import nios_pio_pkg::*;
#(
  parameter int unsigned WIDTH     = 1,
  parameter int unsigned EDGE_TYPE = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] edges
);

  logic [WIDTH-1:0] s1, s2, s3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign sync = s2;

  generate
    if (EDGE_TYPE == EDGE_FALL) begin : g_fall
      assign edges = ~s2 & s3;
    end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
      assign edges = s2 ^ s3;
    end else begin : g_rise
      assign edges = s2 & ~s3;
    end
  endgenerate

endmodule

// File: rtl/nios_pio_in_cap.sv
// Avalon-MM input port with synchroniser, masked edge capture and strobe-loaded snapshot.
module nios_pio_in_cap
  import nios_pio_pkg::*;
#(
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned EDGE_TYPE  = EDGE_RISE,
  parameter logic [31:0] RESET_MASK = 32'h0
) (
  input  logic               clk,
  input  logic               reset,
  nios_pio_in_cap_if.slave   bus,
  input  logic [DATA_W-1:0]  in_port,
  input  logic               snap_strobe,
  output logic               irq
);

  logic [DATA_W-1:0] data;
  logic [DATA_W-1:0] in_edges;
  logic              snap_edge;
  logic              unused_snap_level;
  logic              unused_wdata;

  logic [DATA_W-1:0] edge_cap, edge_cap_d;
  logic [DATA_W-1:0] irq_mask, irq_mask_d;
  logic [DATA_W-1:0] snapshot, snapshot_d;
  logic              snap_irq_en, snap_irq_en_d;
  logic              snap_valid, snap_valid_d;
  logic              snap_ovf, snap_ovf_d;
  logic [31:0]       rdata_d;
  logic              irq_d;

  logic              wr_en, rd_en, snap_read;
  logic [DATA_W-1:0] wdata;

  pio_sync_edge #(
    .WIDTH     (DATA_W),
    .EDGE_TYPE (EDGE_TYPE)
  ) u_in_sync (
    .clk   (clk),
    .reset (reset),
    .din   (in_port),
    .sync  (data),
    .edges (in_edges)
  );

  pio_sync_edge #(
    .WIDTH     (1),
    .EDGE_TYPE (EDGE_RISE)
  ) u_snap_sync (
    .clk   (clk),
    .reset (reset),
    .din   (snap_strobe),
    .sync  (unused_snap_level),
    .edges (snap_edge)
  );

  assign wr_en        = bus.chipselect & ~bus.write_n;
  assign rd_en        = bus.chipselect & bus.read;
  assign wdata        = bus.writedata[DATA_W-1:0];
  assign snap_read    = rd_en && (bus.address == ADDR_SNAPSHOT);
  assign unused_wdata = ^bus.writedata;

  always_comb begin
    irq_mask_d    = irq_mask;
    snap_irq_en_d = snap_irq_en;
    snapshot_d    = snapshot;

    if (wr_en && bus.address == ADDR_IRQ_MASK) irq_mask_d = wdata;
    if (wr_en && bus.address == ADDR_CTRL)     snap_irq_en_d = bus.writedata[0];

    // New edges are OR'd in after the W1C so a coincident edge survives the clear.
    edge_cap_d = edge_cap;
    if (wr_en && bus.address == ADDR_EDGE_CAP) edge_cap_d = edge_cap & ~wdata;
    edge_cap_d = edge_cap_d | in_edges;

    if (snap_edge) snapshot_d = data;
    snap_valid_d = snap_edge | (snap_valid & ~snap_read);

    // A load coinciding with the consuming read is not an overflow.
    snap_ovf_d = snap_ovf;
    if (wr_en && bus.address == ADDR_STATUS && bus.writedata[STAT_OVF_BIT]) snap_ovf_d = 1'b0;
    if (snap_edge && snap_valid && !snap_read) snap_ovf_d = 1'b1;
  end

  always_comb begin
    rdata_d = '0;
    unique case (bus.address)
      ADDR_DATA:     rdata_d = 32'(data);
      ADDR_SNAPSHOT: rdata_d = 32'(snapshot);
      ADDR_IRQ_MASK: rdata_d = 32'(irq_mask);
      ADDR_EDGE_CAP: rdata_d = 32'(edge_cap);
      ADDR_CTRL:     rdata_d = {31'b0, snap_irq_en};
      ADDR_STATUS:   begin
        rdata_d[STAT_VALID_BIT] = snap_valid;
        rdata_d[STAT_OVF_BIT]   = snap_ovf;
      end
      default:       rdata_d = '0;
    endcase
  end

  assign irq_d = (|(edge_cap & irq_mask)) | (snap_valid & snap_irq_en);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.readdata <= '0;
      irq          <= 1'b0;
      edge_cap     <= '0;
      irq_mask     <= RESET_MASK[DATA_W-1:0];
      snapshot     <= '0;
      snap_irq_en  <= 1'b0;
      snap_valid   <= 1'b0;
      snap_ovf     <= 1'b0;
    end else begin
      bus.readdata <= rdata_d;
      irq          <= irq_d;
      edge_cap     <= edge_cap_d;
      irq_mask     <= irq_mask_d;
      snapshot     <= snapshot_d;
      snap_irq_en  <= snap_irq_en_d;
      snap_valid   <= snap_valid_d;
      snap_ovf     <= snap_ovf_d;
    end
  end

endmodule

// File: tb/tb_nios_pio_in_cap.sv
// Directed bench for nios_pio_in_cap with the default 24-bit, rising-edge configuration.
module tb_nios_pio_in_cap;

  logic        clk;
  logic        reset;
  logic [23:0] in_port;
  logic        snap_strobe;
  logic        irq;
  int          n_pass;
  int          n_total;

  nios_pio_in_cap_if bus_if ();

  nios_pio_in_cap #(
    .DATA_W     (24),
    .EDGE_TYPE  (0),
    .RESET_MASK (32'h0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus_if),
    .in_port     (in_port),
    .snap_strobe (snap_strobe),
    .irq         (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_if.address    = a;
    bus_if.writedata  = d;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    bus_if.address    = a;
    bus_if.chipselect = 1'b1;
    bus_if.read       = 1'b1;
    @(posedge clk);
    #1;
    d = bus_if.readdata;
    bus_if.chipselect = 1'b0;
    bus_if.read       = 1'b0;
  endtask

  task automatic strobe_pulse();
    @(negedge clk);
    snap_strobe = 1'b1;
    @(negedge clk);
    snap_strobe = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset = 1'b1;
    tick(3);
    @(negedge clk);
    reset = 1'b0;
    tick(2);
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), rd);
      n_total++;
      if (rd !== 32'h0) $display("FAIL reset_read_addr%0d: got %h expected %h", a, rd, 32'h0);
      else n_pass++;
    end
    n_total++;
    if (irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", irq);
    else n_pass++;
  endtask

  task automatic test_data_edge();
    logic [31:0] rd;
    @(negedge clk);
    in_port = 24'hA5A5A5;
    @(posedge clk);
    @(posedge clk);
    bus_read(3'd0, rd);
    n_total++;
    if (rd !== 32'h00A5A5A5) $display("FAIL data_latency: got %h expected %h", rd, 32'h00A5A5A5);
    else n_pass++;
    tick(1);
    bus_read(3'd3, rd);
    n_total++;
    if (rd !== 32'h00A5A5A5) $display("FAIL edge_cap_rise: got %h expected %h", rd, 32'h00A5A5A5);
    else n_pass++;
    bus_write(3'd3, 32'h5);
    bus_read(3'd3, rd);
    n_total++;
    if (rd !== 32'h00A5A5A0) $display("FAIL edge_cap_w1c: got %h expected %h", rd, 32'h00A5A5A0);
    else n_pass++;
    bus_write(3'd3, 32'h00FFFFFF);
    tick(1);
    n_total++;
    if (irq !== 1'b0) $display("FAIL irq_masked: got %b expected 0", irq);
    else n_pass++;
  endtask

  task automatic test_edge_irq();
    logic [31:0] rd;
    @(negedge clk);
    in_port = 24'hA5A5A4;
    tick(5);
    bus_write(3'd3, 32'h00FFFFFF);
    bus_write(3'd2, 32'h1);
    bus_read(3'd3, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL no_fall_capture: got %h expected %h", rd, 32'h0);
    else n_pass++;
    @(negedge clk);
    in_port = 24'hA5A5A5;
    tick(5);
    n_total++;
    if (irq !== 1'b1) $display("FAIL irq_on_edge: got %b expected 1", irq);
    else n_pass++;
    bus_write(3'd3, 32'h1);
    n_total++;
    if (irq !== 1'b1) $display("FAIL irq_lag_on_clear: got %b expected 1", irq);
    else n_pass++;
    tick(1);
    n_total++;
    if (irq !== 1'b0) $display("FAIL irq_after_clear: got %b expected 0", irq);
    else n_pass++;
    // Arrange a rising edge on bit0 to land in the same cycle as a W1C of bit0.
    @(negedge clk);
    in_port = 24'hA5A5A4;
    tick(5);
    @(negedge clk);
    in_port = 24'hA5A5A5;
    @(posedge clk);
    @(posedge clk);
    bus_write(3'd3, 32'h1);
    bus_read(3'd3, rd);
    n_total++;
    if (rd !== 32'h1) $display("FAIL set_beats_w1c: got %h expected %h", rd, 32'h1);
    else n_pass++;
    n_total++;
    if (irq !== 1'b1) $display("FAIL irq_set_beats_w1c: got %b expected 1", irq);
    else n_pass++;
    bus_write(3'd3, 32'h1);
    bus_write(3'd2, 32'h0);
    tick(2);
  endtask

  task automatic test_snapshot();
    logic [31:0] rd;
    @(negedge clk);
    in_port = 24'h123456;
    tick(4);
    strobe_pulse();
    tick(4);
    @(negedge clk);
    in_port = 24'hFFFFFF;
    tick(4);
    bus_read(3'd5, rd);
    n_total++;
    if (rd !== 32'h1) $display("FAIL status_valid: got %h expected %h", rd, 32'h1);
    else n_pass++;
    bus_read(3'd1, rd);
    n_total++;
    if (rd !== 32'h00123456) $display("FAIL snapshot_value: got %h expected %h", rd, 32'h00123456);
    else n_pass++;
    bus_read(3'd5, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL status_after_read: got %h expected %h", rd, 32'h0);
    else n_pass++;
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    strobe_pulse();
    tick(4);
    strobe_pulse();
    tick(4);
    bus_read(3'd5, rd);
    n_total++;
    if (rd !== 32'h3) $display("FAIL status_ovf: got %h expected %h", rd, 32'h3);
    else n_pass++;
    bus_write(3'd5, 32'h2);
    bus_read(3'd5, rd);
    n_total++;
    if (rd !== 32'h1) $display("FAIL ovf_clear: got %h expected %h", rd, 32'h1);
    else n_pass++;
    bus_write(3'd4, 32'h1);
    bus_read(3'd4, rd);
    n_total++;
    if (rd !== 32'h1) $display("FAIL ctrl_read: got %h expected %h", rd, 32'h1);
    else n_pass++;
    n_total++;
    if (irq !== 1'b1) $display("FAIL irq_snap_valid: got %b expected 1", irq);
    else n_pass++;
    bus_read(3'd1, rd);
    tick(1);
    n_total++;
    if (irq !== 1'b0) $display("FAIL irq_snap_consumed: got %b expected 0", irq);
    else n_pass++;
    bus_write(3'd4, 32'h0);
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] rd;
    @(negedge clk);
    in_port = 24'h0;
    tick(5);
    bus_write(3'd3, 32'h00FFFFFF);
    @(negedge clk);
    in_port = 24'h0000FF;
    tick(5);
    bus_write(3'd2, 32'h000000FF);
    bus_read(3'd3, rd);
    n_total++;
    if (rd !== 32'hFF) $display("FAIL edge_cap_ff: got %h expected %h", rd, 32'hFF);
    else n_pass++;
    tick(1);
    n_total++;
    if (irq !== 1'b1) $display("FAIL irq_before_reset: got %b expected 1", irq);
    else n_pass++;
    @(negedge clk);
    bus_if.address    = 3'd2;
    bus_if.writedata  = 32'hABC;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    n_total++;
    if (irq !== 1'b0 || bus_if.readdata !== 32'h0)
      $display("FAIL async_reset: got irq=%b rd=%h expected irq=0 rd=00000000", irq,
               bus_if.readdata);
    else n_pass++;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    in_port = 24'h000010;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    tick(4);
    bus_read(3'd3, rd);
    n_total++;
    if (rd !== 32'h10) $display("FAIL post_reset_edge: got %h expected %h", rd, 32'h10);
    else n_pass++;
    bus_read(3'd2, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL post_reset_mask: got %h expected %h", rd, 32'h0);
    else n_pass++;
    bus_read(3'd1, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL post_reset_snapshot: got %h expected %h", rd, 32'h0);
    else n_pass++;
    bus_read(3'd0, rd);
    n_total++;
    if (rd !== 32'h10) $display("FAIL post_reset_data: got %h expected %h", rd, 32'h10);
    else n_pass++;
  endtask

  initial begin
    n_pass            = 0;
    n_total           = 0;
    reset             = 1'b1;
    in_port           = '0;
    snap_strobe       = 1'b0;
    bus_if.address    = '0;
    bus_if.chipselect = 1'b0;
    bus_if.read       = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = '0;
    test_reset();
    test_data_edge();
    test_edge_irq();
    test_snapshot();
    test_overflow();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
